// File: rtl/dco_tune_ctrl_if.sv
// Control/observation bundle for the DCO tuning controller.
// The master drives the loop inputs and the slave (the controller) drives the DCO words.
interface dco_tune_ctrl_if;
  logic        en;
  logic        ferr_valid;
  logic        ferr_sign;
  logic        tw_valid;
  logic [11:0] tw;
  logic [8:0]  dctrl;
  logic [3:0]  dctrltc;
  logic        dctrltcdsm;
  logic        lock;
  logic [1:0]  state;

  modport master (
    output en, ferr_valid, ferr_sign, tw_valid, tw,
    input  dctrl, dctrltc, dctrltcdsm, lock, state
  );

  modport slave (
    input  en, ferr_valid, ferr_sign, tw_valid, tw,
    output dctrl, dctrltc, dctrltcdsm, lock, state
  );
endinterface

// File: rtl/dco_tune_ctrl.sv
// DCO tuning controller: 9-bit successive-approximation coarse band calibration,
// then fine tracking with an integer word plus a first-order delta-sigma dither bit.
module dco_tune_ctrl #(
  parameter logic [3:0] TC_MID    = 4'd8,
  parameter logic [8:0] DCTRL_MID = 9'h100
) (
  input  logic           clk,
  input  logic           rstn,
  dco_tune_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CAL   = 2'b01,
    TRACK = 2'b10
  } state_t;

  localparam logic [8:0] SAR_START = 9'h100;

  state_t      state_reg;
  logic [8:0]  dctrl_reg;
  logic [3:0]  ptr_reg;
  logic [3:0]  dctrltc_reg;
  logic        dsm_reg;
  logic        lock_reg;
  logic [7:0]  acc_reg;
  logic [11:0] tw_q;
  logic [8:0]  dsm_sum;
  logic [8:0]  sar_bit;
  logic [8:0]  sar_next_bit;

  // The bit under test and the one to trial-set next; the latter is zero at pointer 0.
  assign sar_bit      = 9'd1 << ptr_reg;
  assign sar_next_bit = sar_bit >> 1;
  assign dsm_sum      = {1'b0, acc_reg} + {1'b0, tw_q[7:0]};

  // The tracking word is captured regardless of state, even while EN is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tw_q <= 12'h800;
    end else if (bus.tw_valid) begin
      tw_q <= bus.tw;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      dctrl_reg   <= DCTRL_MID;
      ptr_reg     <= 4'd8;
      dctrltc_reg <= TC_MID;
      dsm_reg     <= 1'b0;
      lock_reg    <= 1'b0;
      acc_reg     <= 8'h00;
    end else if (!bus.en) begin
      // Dropping EN wins over any calibration decision on the same edge.
      state_reg   <= IDLE;
      dctrl_reg   <= DCTRL_MID;
      ptr_reg     <= 4'd8;
      dctrltc_reg <= TC_MID;
      dsm_reg     <= 1'b0;
      lock_reg    <= 1'b0;
      acc_reg     <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= CAL;
          dctrl_reg <= SAR_START;
          ptr_reg   <= 4'd8;
        end
        CAL: begin
          if (bus.ferr_valid) begin
            // A fast DCO means the trial bit overshot, so it is dropped.
            dctrl_reg <= (bus.ferr_sign ? (dctrl_reg & ~sar_bit) : dctrl_reg) | sar_next_bit;
            if (ptr_reg == 4'd0) begin
              state_reg <= TRACK;
              lock_reg  <= 1'b1;
            end else begin
              ptr_reg <= ptr_reg - 4'd1;
            end
          end
        end
        TRACK: begin
          dctrltc_reg         <= tw_q[11:8];
          {dsm_reg, acc_reg}  <= dsm_sum;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.dctrl      = dctrl_reg;
  assign bus.dctrltc    = dctrltc_reg;
  assign bus.dctrltcdsm = dsm_reg;
  assign bus.lock       = lock_reg;
  assign bus.state      = state_reg;
endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Directed bench for dco_tune_ctrl: an arithmetic reference model checked every cycle,
// plus literal expectations for calibration, dither density, abort, reset and collisions.
module tb_dco_tune_ctrl;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int tests_run    = 0;
  int tests_failed = 0;

  dco_tune_ctrl_if ifc();

  dco_tune_ctrl #(
    .TC_MID   (4'd8),
    .DCTRL_MID(9'h100)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 cal, 2 track; band word as a plain integer.
  int m_state = 0;
  int m_dctrl = 256;
  int m_ptr   = 8;
  int m_tc    = 8;
  int m_dsm   = 0;
  int m_lock  = 0;
  int m_twq   = 'h800;
  int m_acc   = 0;
  int m_twq_old;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_state = 0; m_dctrl = 256; m_ptr = 8; m_tc = 8;
      m_dsm = 0; m_lock = 0; m_twq = 'h800; m_acc = 0;
    end else begin
      m_twq_old = m_twq;
      if (ifc.tw_valid) m_twq = int'(ifc.tw);
      if (!ifc.en) begin
        m_state = 0; m_dctrl = 256; m_ptr = 8; m_tc = 8;
        m_dsm = 0; m_lock = 0; m_acc = 0;
      end else if (m_state == 0) begin
        m_state = 1; m_dctrl = 256; m_ptr = 8;
      end else if (m_state == 1) begin
        if (ifc.ferr_valid) begin
          if (ifc.ferr_sign) m_dctrl = m_dctrl - (1 << m_ptr);
          if (m_ptr == 0) begin
            m_state = 2; m_lock = 1;
          end else begin
            m_ptr = m_ptr - 1;
            m_dctrl = m_dctrl + (1 << m_ptr);
          end
        end
      end else begin
        m_tc  = m_twq_old / 256;
        m_acc = m_acc + (m_twq_old % 256);
        m_dsm = m_acc / 256;
        m_acc = m_acc % 256;
      end
    end
  end

  logic [16:0] exp_v, dut_v;
  always @(negedge clk) begin
    exp_v = {m_state[1:0], m_dctrl[8:0], m_tc[3:0], m_dsm[0], m_lock[0]};
    dut_v = {ifc.state, ifc.dctrl, ifc.dctrltc, ifc.dctrltcdsm, ifc.lock};
    tests_run++;
    if (dut_v !== exp_v) begin
      tests_failed++;
      $display("FAIL cycle_cmp t=%0t: dut state=%0d dctrl=0x%03h tc=%0d dsm=%0d lock=%0d, model state=%0d dctrl=0x%03h tc=%0d dsm=%0d lock=%0d",
               $time, ifc.state, ifc.dctrl, ifc.dctrltc, ifc.dctrltcdsm, ifc.lock,
               m_state, m_dctrl, m_tc, m_dsm, m_lock);
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_state"}, int'(ifc.state), 0);
    check({name, "_dctrl"}, int'(ifc.dctrl), 'h100);
    check({name, "_tc"},    int'(ifc.dctrltc), 8);
    check({name, "_dsm"},   int'(ifc.dctrltcdsm), 0);
    check({name, "_lock"},  int'(ifc.lock), 0);
  endtask

  task automatic ferr_pulse(input logic s, input int gap);
    ifc.ferr_valid = 1'b1;
    ifc.ferr_sign  = s;
    @(negedge clk);
    ifc.ferr_valid = 1'b0;
    $display("[TB] ferr sign=%0d -> dctrl=0x%03h state=%0d lock=%0d", s, ifc.dctrl, ifc.state, ifc.lock);
    repeat (gap) @(negedge clk);
  endtask

  task automatic calibrate(input logic [8:0] signs, input int gap);
    for (int i = 8; i >= 0; i--) ferr_pulse(signs[i], gap);
  endtask

  task automatic start_cal(input string name);
    ifc.en = 1'b1;
    @(negedge clk);
    check({name, "_cal_state"}, int'(ifc.state), 1);
    check({name, "_cal_dctrl"}, int'(ifc.dctrl), 'h100);
    $display("[TB] %s: CAL entered, dctrl=0x%03h", name, ifc.dctrl);
  endtask

  task automatic write_tw(input logic [11:0] w);
    ifc.tw_valid = 1'b1;
    ifc.tw       = w;
    @(negedge clk);
    ifc.tw_valid = 1'b0;
    $display("[TB] tw write 0x%03h", w);
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      ones += int'(ifc.dctrltcdsm);
      @(negedge clk);
    end
  endtask

  int ones;

  initial begin
    ifc.en = 1'b0; ifc.ferr_valid = 1'b0; ifc.ferr_sign = 1'b0;
    ifc.tw_valid = 1'b0; ifc.tw = 12'h000;

    // Reset values while RSTN is held low.
    repeat (3) @(negedge clk);
    check_idle("reset");
    rstn = 1'b1;

    // No state change without EN; FERR in IDLE ignored.
    ferr_pulse(1'b1, 2);
    check_idle("idle_hold");

    // Gapless calibration.
    start_cal("cal1");
    calibrate(9'b1_0110_0101, 0);
    check("cal1_dctrl", int'(ifc.dctrl), 'h09A);
    check("cal1_lock",  int'(ifc.lock), 1);
    check("cal1_state", int'(ifc.state), 2);

    // Dither: 0x40/256 gives one carry every fourth cycle.
    write_tw(12'h940);
    @(negedge clk);
    check("dsm_tc", int'(ifc.dctrltc), 9);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("dsm_pat%0d", i), int'(ifc.dctrltcdsm), (i % 4 == 3) ? 1 : 0);
      @(negedge clk);
    end
    count_ones(256, ones);
    $display("[TB] tw=0x940 ones in 256 cycles: %0d", ones);
    check("dsm_ones_40", ones, 64);

    // Stalled calibration reaches the same band.
    ifc.en = 1'b0;
    @(negedge clk);
    check_idle("drop1");
    start_cal("cal2");
    calibrate(9'b1_0110_0101, 5);
    check("cal2_dctrl", int'(ifc.dctrl), 'h09A);
    check("cal2_lock",  int'(ifc.lock), 1);

    // Abort after four decisions, then restart.
    ifc.en = 1'b0;
    @(negedge clk);
    start_cal("cal3");
    for (int i = 0; i < 4; i++) ferr_pulse(1'b1, 0);
    check("abort_mid_dctrl", int'(ifc.dctrl), 'h010);
    ifc.en = 1'b0;
    @(negedge clk);
    check_idle("abort");
    start_cal("cal4");
    calibrate(9'b0_0000_0000, 0);
    check("cal4_dctrl", int'(ifc.dctrl), 'h1FF);
    ferr_pulse(1'b1, 1);
    check("track_ferr_ignored", int'(ifc.dctrl), 'h1FF);

    // Asynchronous reset mid-TRACK.
    write_tw(12'hFFF);
    repeat (3) @(negedge clk);
    #2;
    rstn = 1'b0;
    ifc.en = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    start_cal("cal5");
    calibrate(9'b0_0000_0000, 0);
    @(negedge clk);
    check("rst_twq_tc", int'(ifc.dctrltc), 8);
    count_ones(16, ones);
    check("rst_twq_dsm_ones", ones, 0);

    // EN drop collides with the bit-0 decision and a TW capture.
    ifc.en = 1'b0;
    @(negedge clk);
    start_cal("cal6");
    for (int i = 0; i < 8; i++) ferr_pulse(1'b0, 0);
    ifc.en = 1'b0; ifc.ferr_valid = 1'b1; ifc.ferr_sign = 1'b1;
    ifc.tw_valid = 1'b1; ifc.tw = 12'h5A3;
    @(negedge clk);
    ifc.ferr_valid = 1'b0; ifc.tw_valid = 1'b0;
    $display("[TB] collision edge -> state=%0d lock=%0d", ifc.state, ifc.lock);
    check_idle("collide");
    start_cal("cal7");
    calibrate(9'b0_0000_0000, 0);
    @(negedge clk);
    check("collide_twq_tc", int'(ifc.dctrltc), 5);
    count_ones(256, ones);
    $display("[TB] tw=0x5A3 ones in 256 cycles: %0d", ones);
    check("dsm_ones_a3", ones, 163);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
